// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_hazard_ctrl
// Purpose  : 5-stage pipeline hazard unit. It provides operand forwarding,
//            load-use and HI/LO stalls, ID redirect flush, mult/div busy
//            tracking and a saturating stall counter.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl #(
   parameter int MD_LAT = 8
) (
   input  logic        Clk,
   input  logic        Clr,
   input  logic [4:0]  ID_Rs,
   input  logic [4:0]  ID_Rt,
   input  logic        ID_UseRs,
   input  logic        ID_UseRt,
   input  logic        ID_UsesHiLo,
   input  logic        ID_Redirect,
   input  logic        EX_Wreg,
   input  logic        EX_Mem2Reg,
   input  logic [4:0]  EX_Rd,
   input  logic        MEM_Wreg,
   input  logic        MEM_Mem2Reg,
   input  logic [4:0]  MEM_Rd,
   input  logic        EX_MDStart,
   output logic        PC_Wen,
   output logic        IFID_Wen,
   output logic        IFID_Flush,
   output logic        IDEX_Bubble,
   output logic [1:0]  FwdA,
   output logic [1:0]  FwdB,
   output logic        MD_Busy,
   output logic [15:0] Stall_Cnt
);

   localparam logic [3:0] c_MD_RELOAD = 4'(MD_LAT - 1);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } md_state_t;

   md_state_t   r_md_state;
   md_state_t   w_md_state_nxt;
   logic [3:0]  r_md_cnt;
   logic [3:0]  w_md_cnt_nxt;
   logic [15:0] r_stall_cnt;

   logic w_ex_hit_a;
   logic w_ex_hit_b;
   logic w_mem_hit_a;
   logic w_mem_hit_b;
   logic w_load_use;
   logic w_hilo_stall;
   logic w_stall;

   // $0 is hard-wired, so a write to it never creates a dependency
   assign w_ex_hit_a  = ID_UseRs && EX_Wreg  && (EX_Rd  != 5'd0) && (EX_Rd  == ID_Rs);
   assign w_ex_hit_b  = ID_UseRt && EX_Wreg  && (EX_Rd  != 5'd0) && (EX_Rd  == ID_Rt);
   assign w_mem_hit_a = ID_UseRs && MEM_Wreg && (MEM_Rd != 5'd0) && (MEM_Rd == ID_Rs);
   assign w_mem_hit_b = ID_UseRt && MEM_Wreg && (MEM_Rd != 5'd0) && (MEM_Rd == ID_Rt);

   assign w_load_use   = EX_Mem2Reg && (w_ex_hit_a || w_ex_hit_b);
   assign w_hilo_stall = MD_Busy && ID_UsesHiLo;
   assign w_stall      = w_load_use || w_hilo_stall;

   assign MD_Busy   = (r_md_state == ST_BUSY);
   assign Stall_Cnt = r_stall_cnt;

   always_comb begin
      FwdA = 2'b00;
      if (w_ex_hit_a && !EX_Mem2Reg) begin
         FwdA = 2'b01;
      end else if (w_mem_hit_a && !MEM_Mem2Reg) begin
         FwdA = 2'b10;
      end else if (w_mem_hit_a) begin
         FwdA = 2'b11;
      end

      FwdB = 2'b00;
      if (w_ex_hit_b && !EX_Mem2Reg) begin
         FwdB = 2'b01;
      end else if (w_mem_hit_b && !MEM_Mem2Reg) begin
         FwdB = 2'b10;
      end else if (w_mem_hit_b) begin
         FwdB = 2'b11;
      end
   end

   // A stall holds the redirecting instruction in ID; it flushes once released
   always_comb begin
      PC_Wen      = 1'b1;
      IFID_Wen    = 1'b1;
      IFID_Flush  = 1'b0;
      IDEX_Bubble = 1'b0;
      if (w_stall) begin
         PC_Wen      = 1'b0;
         IFID_Wen    = 1'b0;
         IDEX_Bubble = 1'b1;
      end else if (ID_Redirect) begin
         IFID_Flush  = 1'b1;
      end
   end

   always_comb begin
      w_md_state_nxt = r_md_state;
      w_md_cnt_nxt   = r_md_cnt;
      case (r_md_state)
         ST_IDLE: begin
            if (EX_MDStart) begin
               w_md_state_nxt = ST_BUSY;
               w_md_cnt_nxt   = c_MD_RELOAD;
            end
         end
         ST_BUSY: begin
            if (EX_MDStart) begin
               w_md_cnt_nxt   = c_MD_RELOAD;
            end else if (r_md_cnt != 4'd0) begin
               w_md_cnt_nxt   = r_md_cnt - 4'd1;
            end else begin
               w_md_state_nxt = ST_IDLE;
            end
         end
         default: begin
            w_md_state_nxt = ST_IDLE;
            w_md_cnt_nxt   = 4'd0;
         end
      endcase
   end

   // State moves on the falling edge, together with the pipeline registers
   always_ff @(negedge Clk) begin
      if (Clr) begin
         r_md_state  <= ST_IDLE;
         r_md_cnt    <= 4'd0;
         r_stall_cnt <= 16'd0;
      end else begin
         r_md_state <= w_md_state_nxt;
         r_md_cnt   <= w_md_cnt_nxt;
         if (w_stall && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_hazard_ctrl
// Purpose  : Directed and randomized checks of pipe_hazard_ctrl against a
//            cycle-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

   localparam int MD_LAT = 8;

   logic        Clk = 1'b0;
   logic        Clr;
   logic [4:0]  ID_Rs, ID_Rt, EX_Rd, MEM_Rd;
   logic        ID_UseRs, ID_UseRt, ID_UsesHiLo, ID_Redirect;
   logic        EX_Wreg, EX_Mem2Reg, MEM_Wreg, MEM_Mem2Reg, EX_MDStart;
   logic        PC_Wen, IFID_Wen, IFID_Flush, IDEX_Bubble, MD_Busy;
   logic [1:0]  FwdA, FwdB;
   logic [15:0] Stall_Cnt;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model state: cycles of busy remaining, and the stall count
   int m_busy_left = 0;
   int m_stall_cnt = 0;

   pipe_hazard_ctrl #(.MD_LAT(MD_LAT)) dut (
      .Clk(Clk), .Clr(Clr),
      .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UseRs(ID_UseRs), .ID_UseRt(ID_UseRt),
      .ID_UsesHiLo(ID_UsesHiLo), .ID_Redirect(ID_Redirect),
      .EX_Wreg(EX_Wreg), .EX_Mem2Reg(EX_Mem2Reg), .EX_Rd(EX_Rd),
      .MEM_Wreg(MEM_Wreg), .MEM_Mem2Reg(MEM_Mem2Reg), .MEM_Rd(MEM_Rd),
      .EX_MDStart(EX_MDStart),
      .PC_Wen(PC_Wen), .IFID_Wen(IFID_Wen), .IFID_Flush(IFID_Flush),
      .IDEX_Bubble(IDEX_Bubble), .FwdA(FwdA), .FwdB(FwdB),
      .MD_Busy(MD_Busy), .Stall_Cnt(Stall_Cnt)
   );

   always #5 Clk = ~Clk;

   function automatic logic hit(input logic [4:0] src, input logic use_src,
                                input logic wreg, input logic [4:0] rd);
      return use_src && wreg && (rd != 5'd0) && (rd == src);
   endfunction

   function automatic logic [1:0] ref_fwd(input logic [4:0] src, input logic use_src);
      if (hit(src, use_src, EX_Wreg, EX_Rd) && !EX_Mem2Reg) return 2'b01;
      if (hit(src, use_src, MEM_Wreg, MEM_Rd)) return MEM_Mem2Reg ? 2'b11 : 2'b10;
      return 2'b00;
   endfunction

   function automatic logic ref_stall();
      logic load_use;
      load_use = EX_Mem2Reg && (hit(ID_Rs, ID_UseRs, EX_Wreg, EX_Rd) ||
                                hit(ID_Rt, ID_UseRt, EX_Wreg, EX_Rd));
      return load_use || ((m_busy_left > 0) && ID_UsesHiLo);
   endfunction

   task automatic model_edge();
      logic st;
      st = ref_stall();
      if (Clr) begin
         m_busy_left = 0;
         m_stall_cnt = 0;
      end else begin
         if (EX_MDStart) m_busy_left = MD_LAT;
         else if (m_busy_left > 0) m_busy_left--;
         if (st && m_stall_cnt < 65535) m_stall_cnt++;
      end
   endtask

   // Inputs change at posedge+1, outputs are checked at posedge+2,
   // the DUT state moves at the negedge
   task automatic next_cycle();
      model_edge();
      @(posedge Clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic clear_inputs();
      Clr = 1'b0; ID_Rs = '0; ID_Rt = '0; EX_Rd = '0; MEM_Rd = '0;
      ID_UseRs = 1'b0; ID_UseRt = 1'b0; ID_UsesHiLo = 1'b0; ID_Redirect = 1'b0;
      EX_Wreg = 1'b0; EX_Mem2Reg = 1'b0; MEM_Wreg = 1'b0; MEM_Mem2Reg = 1'b0;
      EX_MDStart = 1'b0;
   endtask

   task automatic set_load_use();
      EX_Wreg = 1'b1; EX_Mem2Reg = 1'b1; EX_Rd = 5'd5; ID_Rs = 5'd5; ID_UseRs = 1'b1;
   endtask

   task automatic test_reset();
      clear_inputs();
      Clr = 1'b1;
      settle();
      next_cycle();
      settle();
      n_tests++; if (MD_Busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", MD_Busy); end
      n_tests++; if (Stall_Cnt !== 16'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d want 0", Stall_Cnt); end
      n_tests++; if (PC_Wen !== 1'b1 || IFID_Wen !== 1'b1) begin n_fail++; $display("FAIL reset_wen: got %b%b want 11", PC_Wen, IFID_Wen); end
      n_tests++; if (IFID_Flush !== 1'b0 || IDEX_Bubble !== 1'b0) begin n_fail++; $display("FAIL reset_flush_bubble: got %b%b want 00", IFID_Flush, IDEX_Bubble); end
      n_tests++; if (FwdA !== 2'b00 || FwdB !== 2'b00) begin n_fail++; $display("FAIL reset_fwd: got %b %b want 00 00", FwdA, FwdB); end
      Clr = 1'b0;
      settle();
      next_cycle();
   endtask

   task automatic test_load_use();
      clear_inputs();
      set_load_use();
      settle();
      n_tests++; if (PC_Wen !== 1'b0 || IFID_Wen !== 1'b0) begin n_fail++; $display("FAIL lu_wen: got %b%b want 00", PC_Wen, IFID_Wen); end
      n_tests++; if (IDEX_Bubble !== 1'b1) begin n_fail++; $display("FAIL lu_bubble: got %b want 1", IDEX_Bubble); end
      next_cycle();
      EX_Wreg = 1'b0; EX_Mem2Reg = 1'b0; EX_Rd = 5'd0;
      MEM_Wreg = 1'b1; MEM_Mem2Reg = 1'b1; MEM_Rd = 5'd5;
      settle();
      n_tests++; if (FwdA !== 2'b11) begin n_fail++; $display("FAIL lu_fwda: got %b want 11", FwdA); end
      n_tests++; if (Stall_Cnt !== 16'd1) begin n_fail++; $display("FAIL lu_cnt: got %0d want 1", Stall_Cnt); end
      n_tests++; if (PC_Wen !== 1'b1) begin n_fail++; $display("FAIL lu_release: got %b want 1", PC_Wen); end
      next_cycle();
   endtask

   task automatic test_fwd_priority();
      clear_inputs();
      EX_Wreg = 1'b1; EX_Rd = 5'd3; MEM_Wreg = 1'b1; MEM_Rd = 5'd3;
      ID_Rt = 5'd3; ID_UseRt = 1'b1;
      settle();
      n_tests++; if (FwdB !== 2'b01) begin n_fail++; $display("FAIL fwd_ex_wins: got %b want 01", FwdB); end
      EX_Rd = 5'd7;
      settle();
      n_tests++; if (FwdB !== 2'b10) begin n_fail++; $display("FAIL fwd_mem_alu: got %b want 10", FwdB); end
      ID_UseRt = 1'b0;
      settle();
      n_tests++; if (FwdB !== 2'b00) begin n_fail++; $display("FAIL fwd_unused: got %b want 00", FwdB); end
      clear_inputs();
      EX_Wreg = 1'b1; EX_Mem2Reg = 1'b1; EX_Rd = 5'd0; ID_Rs = 5'd0; ID_UseRs = 1'b1;
      settle();
      n_tests++; if (FwdA !== 2'b00) begin n_fail++; $display("FAIL fwd_zero: got %b want 00", FwdA); end
      n_tests++; if (PC_Wen !== 1'b1 || IDEX_Bubble !== 1'b0) begin n_fail++; $display("FAIL zero_no_stall: got %b%b want 10", PC_Wen, IDEX_Bubble); end
      next_cycle();
   endtask

   task automatic test_hilo();
      clear_inputs();
      Clr = 1'b1;
      settle();
      next_cycle();
      Clr = 1'b0; EX_MDStart = 1'b1; ID_UsesHiLo = 1'b1;
      settle();
      n_tests++; if (MD_Busy !== 1'b0 || PC_Wen !== 1'b1) begin n_fail++; $display("FAIL md_launch: got busy=%b pcw=%b want 0 1", MD_Busy, PC_Wen); end
      next_cycle();
      EX_MDStart = 1'b0;
      for (int i = 0; i < MD_LAT; i++) begin
         settle();
         n_tests++; if (MD_Busy !== 1'b1 || IDEX_Bubble !== 1'b1) begin n_fail++; $display("FAIL md_busy_%0d: got busy=%b bubble=%b want 1 1", i, MD_Busy, IDEX_Bubble); end
         next_cycle();
      end
      settle();
      n_tests++; if (MD_Busy !== 1'b0 || PC_Wen !== 1'b1) begin n_fail++; $display("FAIL md_done: got busy=%b pcw=%b want 0 1", MD_Busy, PC_Wen); end
      n_tests++; if (Stall_Cnt !== 16'(MD_LAT)) begin n_fail++; $display("FAIL md_cnt: got %0d want %0d", Stall_Cnt, MD_LAT); end
      next_cycle();
   endtask

   task automatic test_redirect();
      clear_inputs();
      set_load_use();
      ID_Redirect = 1'b1;
      settle();
      n_tests++; if (IFID_Flush !== 1'b0 || PC_Wen !== 1'b0 || IDEX_Bubble !== 1'b1) begin n_fail++; $display("FAIL redir_stalled: got flush=%b pcw=%b bub=%b want 0 0 1", IFID_Flush, PC_Wen, IDEX_Bubble); end
      next_cycle();
      EX_Wreg = 1'b0; EX_Mem2Reg = 1'b0; EX_Rd = 5'd0;
      settle();
      n_tests++; if (IFID_Flush !== 1'b1 || PC_Wen !== 1'b1 || IFID_Wen !== 1'b1) begin n_fail++; $display("FAIL redir_flush: got flush=%b pcw=%b ifw=%b want 1 1 1", IFID_Flush, PC_Wen, IFID_Wen); end
      next_cycle();
   endtask

   task automatic test_reset_mid_busy();
      int n_busy;
      clear_inputs();
      EX_MDStart = 1'b1; ID_UsesHiLo = 1'b1;
      settle();
      next_cycle();
      EX_MDStart = 1'b0;
      settle();
      n_tests++; if (MD_Busy !== 1'b1) begin n_fail++; $display("FAIL rmb_busy: got %b want 1", MD_Busy); end
      next_cycle();
      next_cycle();
      Clr = 1'b1;
      settle();
      next_cycle();
      Clr = 1'b0;
      settle();
      n_tests++; if (MD_Busy !== 1'b0) begin n_fail++; $display("FAIL rmb_abort: got %b want 0", MD_Busy); end
      n_tests++; if (Stall_Cnt !== 16'd0) begin n_fail++; $display("FAIL rmb_cnt: got %0d want 0", Stall_Cnt); end
      EX_MDStart = 1'b1;
      settle();
      next_cycle();
      EX_MDStart = 1'b0;
      n_busy = 0;
      for (int i = 0; i < 20; i++) begin
         settle();
         if (MD_Busy === 1'b1) n_busy++;
         next_cycle();
      end
      n_tests++; if (n_busy != MD_LAT) begin n_fail++; $display("FAIL rmb_relaunch: got %0d busy cycles want %0d", n_busy, MD_LAT); end
   endtask

   task automatic test_random();
      logic [1:0] e_fa, e_fb;
      logic       e_st;
      for (int i = 0; i < 3000; i++) begin
         Clr         = ($urandom_range(0, 63) == 0);
         ID_Rs       = 5'($urandom_range(0, 3));
         ID_Rt       = 5'($urandom_range(0, 3));
         EX_Rd       = 5'($urandom_range(0, 3));
         MEM_Rd      = 5'($urandom_range(0, 3));
         ID_UseRs    = 1'($urandom);
         ID_UseRt    = 1'($urandom);
         ID_UsesHiLo = 1'($urandom);
         ID_Redirect = ($urandom_range(0, 3) == 0);
         EX_Wreg     = 1'($urandom);
         EX_Mem2Reg  = ($urandom_range(0, 3) == 0);
         MEM_Wreg    = 1'($urandom);
         MEM_Mem2Reg = 1'($urandom);
         EX_MDStart  = ($urandom_range(0, 11) == 0);
         settle();
         e_fa = ref_fwd(ID_Rs, ID_UseRs);
         e_fb = ref_fwd(ID_Rt, ID_UseRt);
         e_st = ref_stall();
         n_tests++; if (FwdA !== e_fa) begin n_fail++; $display("FAIL rnd_fwda[%0d]: got %b want %b", i, FwdA, e_fa); end
         n_tests++; if (FwdB !== e_fb) begin n_fail++; $display("FAIL rnd_fwdb[%0d]: got %b want %b", i, FwdB, e_fb); end
         n_tests++; if (PC_Wen !== !e_st || IFID_Wen !== !e_st) begin n_fail++; $display("FAIL rnd_wen[%0d]: got %b%b want %b%b", i, PC_Wen, IFID_Wen, !e_st, !e_st); end
         n_tests++; if (IDEX_Bubble !== e_st) begin n_fail++; $display("FAIL rnd_bubble[%0d]: got %b want %b", i, IDEX_Bubble, e_st); end
         n_tests++; if (IFID_Flush !== (!e_st && ID_Redirect)) begin n_fail++; $display("FAIL rnd_flush[%0d]: got %b want %b", i, IFID_Flush, !e_st && ID_Redirect); end
         n_tests++; if (MD_Busy !== (m_busy_left > 0)) begin n_fail++; $display("FAIL rnd_busy[%0d]: got %b want %b", i, MD_Busy, m_busy_left > 0); end
         n_tests++; if (Stall_Cnt !== 16'(m_stall_cnt)) begin n_fail++; $display("FAIL rnd_cnt[%0d]: got %0d want %0d", i, Stall_Cnt, m_stall_cnt); end
         next_cycle();
      end
   endtask

   task automatic test_saturate();
      clear_inputs();
      Clr = 1'b1;
      settle();
      next_cycle();
      Clr = 1'b0;
      set_load_use();
      for (int i = 0; i < 65534; i++) next_cycle();
      settle();
      n_tests++; if (Stall_Cnt !== 16'hFFFE) begin n_fail++; $display("FAIL sat_pre: got %h want fffe", Stall_Cnt); end
      for (int i = 65534; i < 70000; i++) next_cycle();
      settle();
      n_tests++; if (Stall_Cnt !== 16'hFFFF) begin n_fail++; $display("FAIL sat_hold: got %h want ffff", Stall_Cnt); end
      n_tests++; if (Stall_Cnt !== 16'(m_stall_cnt)) begin n_fail++; $display("FAIL sat_model: got %h want %h", Stall_Cnt, m_stall_cnt); end
      clear_inputs();
      settle();
      next_cycle();
   endtask

   initial begin
      clear_inputs();
      @(posedge Clk);
      #1;
      test_reset();
      test_load_use();
      test_fwd_priority();
      test_hilo();
      test_redirect();
      test_reset_mid_busy();
      test_random();
      test_saturate();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
